// File: rtl/posit_extract_pipe.sv
// Three-stage posit decoder (capture / regime count / field extract) with valid-ready backpressure.
// Optional zero/NaR input counters when POSIT_EXTRACT_STATS_EN is defined.
module posit_extract_pipe #(
    parameter int NBITS = 32,
    parameter int ES    = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NBITS-1:0]                in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NBITS+$clog2(NBITS):0]    out_result,
    output logic [NBITS-2:0]                out_abs
`ifdef POSIT_EXTRACT_STATS_EN
    ,
    input  logic                            cnt_clear,
    output logic [15:0]                     cnt_zero,
    output logic [15:0]                     cnt_inf
`endif
);
    localparam int SCALE_W = $clog2(NBITS) + ES + 1;
    localparam int FRAC_W  = NBITS - ES - 3;
    localparam int M_W     = $clog2(NBITS);
    localparam int STAGES  = 3;

    logic [STAGES:1] vld_pipe;
    logic [STAGES:1] rdy;

    // A stage may load when the one downstream is empty or draining this cycle.
    always_comb begin
        rdy[STAGES] = ~vld_pipe[STAGES] | out_ready;
        for (int i = STAGES - 1; i >= 1; i--)
            rdy[i] = ~vld_pipe[i] | rdy[i+1];
    end

    assign in_ready  = rdy[1];
    assign out_valid = vld_pipe[STAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
        end else begin
            if (rdy[1]) vld_pipe[1] <= in_valid;
            for (int i = 2; i <= STAGES; i++)
                if (rdy[i]) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    // Stage 1: sign, specials, magnitude
    logic             s1_sgn, s1_zero, s1_inf;
    logic [NBITS-2:0] s1_u;
    logic             acc;
    assign acc = in_valid & rdy[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_sgn <= 1'b0; s1_zero <= 1'b0; s1_inf <= 1'b0; s1_u <= '0;
        end else if (acc) begin
            s1_sgn  <= in_data[NBITS-1];
            s1_zero <= (in_data == '0);
            s1_inf  <= (in_data == {1'b1, {(NBITS-1){1'b0}}});
            s1_u    <= in_data[NBITS-1] ? (NBITS-1)'(-in_data) : in_data[NBITS-2:0];
        end
    end

    // Stage 2: regime run length
    logic                      r_c, run;
    logic [M_W-1:0]            m_c, rw_c;
    logic signed [SCALE_W-1:0] k_c;

    always_comb begin
        r_c = s1_u[NBITS-2];
        m_c = '0;
        run = 1'b1;
        for (int i = NBITS - 2; i >= 0; i--) begin
            if (run && (s1_u[i] == r_c)) m_c = m_c + M_W'(1);
            else                         run = 1'b0;
        end
        k_c  = r_c ? SCALE_W'(m_c) - SCALE_W'(1) : SCALE_W'(0) - SCALE_W'(m_c);
        rw_c = (m_c == M_W'(NBITS - 1)) ? m_c : m_c + M_W'(1);
    end

    logic                      s2_sgn, s2_zero, s2_inf;
    logic [NBITS-2:0]          s2_u;
    logic signed [SCALE_W-1:0] s2_k;
    logic [M_W-1:0]            s2_rw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_sgn <= 1'b0; s2_zero <= 1'b0; s2_inf <= 1'b0;
            s2_u <= '0; s2_k <= '0; s2_rw <= '0;
        end else if (vld_pipe[1] && rdy[2]) begin
            s2_sgn <= s1_sgn; s2_zero <= s1_zero; s2_inf <= s1_inf;
            s2_u <= s1_u; s2_k <= k_c; s2_rw <= rw_c;
        end
    end

    // Stage 3: shift out the regime, peel exponent and fraction
    logic [NBITS-2:0]          sh;
    logic [FRAC_W-1:0]         frac_c;
    logic signed [SCALE_W-1:0] scale_c;
    logic                      special;

    assign sh      = s2_u << s2_rw;
    assign frac_c  = FRAC_W'(sh >> 2);
    assign special = s2_zero | s2_inf;

    generate
        if (ES > 0) begin : g_es
            assign scale_c = (s2_k <<< ES) + SCALE_W'(sh[NBITS-2 -: ES]);
        end else begin : g_noes
            assign scale_c = s2_k;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_result <= '0;
            out_abs    <= '0;
        end else if (vld_pipe[2] && rdy[3]) begin
            out_result <= {s2_sgn,
                           special ? SCALE_W'(0) : scale_c,
                           special ? FRAC_W'(0)  : frac_c,
                           s2_inf, s2_zero};
            out_abs    <= s2_u;
        end
    end

`ifdef POSIT_EXTRACT_STATS_EN
    logic in_is_zero, in_is_inf;
    assign in_is_zero = acc && (in_data == '0);
    assign in_is_inf  = acc && (in_data == {1'b1, {(NBITS-1){1'b0}}});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_zero <= '0;
            cnt_inf  <= '0;
        end else if (cnt_clear) begin
            cnt_zero <= '0;
            cnt_inf  <= '0;
        end else begin
            if (in_is_zero && cnt_zero != 16'hFFFF) cnt_zero <= cnt_zero + 16'd1;
            if (in_is_inf  && cnt_inf  != 16'hFFFF) cnt_inf  <= cnt_inf  + 16'd1;
        end
    end
`endif

endmodule
